// File: rtl/fakeram7_req_ctrl.sv
// Request/response front end for one fakeram7 single-port macro: issue is combinational, read data returns >=2 cycles after fire.
// Backpressure: req_ready is a credit check on buffered plus in-flight reads, so a stalled consumer never drops data.
module fakeram7_req_ctrl #(
  parameter int BITS       = 64,
  parameter int WORD_DEPTH = 512,
  parameter int ADDR_WIDTH = 9,
  parameter int RSP_DEPTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [BITS-1:0]       req_wdata,
  input  logic [BITS-1:0]       req_wmask,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [BITS-1:0]       rsp_rdata,
  output logic                  sram_ce,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [BITS-1:0]       sram_wd,
  output logic [BITS-1:0]       sram_wmask,
  input  logic [BITS-1:0]       sram_rd,
  output logic                  busy
);

  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RSP_DEPTH - 1);
  localparam logic [CNT_W:0]   CREDITS  = (CNT_W + 1)'(RSP_DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RSP_DEPTH);

  logic                  fire;
  logic                  push;
  logic                  pop;
  logic                  rd_pending_q, rd_pending_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [BITS-1:0]       rsp_mem_q [RSP_DEPTH];
  logic [BITS-1:0]       rsp_mem_d [RSP_DEPTH];

  // In-flight read holds a FIFO slot, so a full FIFO plus one pending read can never overflow.
  assign req_ready = ({1'b0, count_q} + {{CNT_W{1'b0}}, rd_pending_q}) < CREDITS;
  assign fire      = req_valid & req_ready;

  assign sram_ce    = fire;
  assign sram_we    = fire & req_we;
  assign sram_addr  = fire ? req_addr  : '0;
  assign sram_wd    = fire ? req_wdata : '0;
  assign sram_wmask = fire ? req_wmask : '0;

  // Macro read data is only meaningful the cycle after a read fire.
  assign push      = rd_pending_q;
  assign rsp_valid = (count_q != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign rsp_rdata = rsp_valid ? rsp_mem_q[rd_ptr_q] : '0;
  assign busy      = rd_pending_q | rsp_valid;

  always_comb begin
    rd_pending_d = fire & ~req_we;
    count_d      = count_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    rsp_mem_d    = rsp_mem_q;
    if (push) begin
      rsp_mem_d[wr_ptr_q] = sram_rd;
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pending_q <= 1'b0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      rsp_mem_q    <= '{default: '0};
    end else begin
      rd_pending_q <= rd_pending_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      rsp_mem_q    <= rsp_mem_d;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && count_q == FULL_CNT));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(pop && count_q == '0));
  a_addr_in_range: assert property (@(posedge clk) disable iff (rst)
    !fire || (int'(req_addr) < WORD_DEPTH));

endmodule

// File: tb/tb_fakeram7_req_ctrl.sv
// Bench for fakeram7_req_ctrl: macro model plus a queue-based reference of expected read data and timing.
module tb_fakeram7_req_ctrl;

  localparam int BITS = 64;
  localparam int AW   = 9;
  localparam int DEP  = 512;
  localparam int RSPD = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic            req_we = 1'b0;
  logic [AW-1:0]   req_addr = '0;
  logic [BITS-1:0] req_wdata = '0;
  logic [BITS-1:0] req_wmask = '0;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [BITS-1:0] rsp_rdata;
  logic            sram_ce;
  logic            sram_we;
  logic [AW-1:0]   sram_addr;
  logic [BITS-1:0] sram_wd;
  logic [BITS-1:0] sram_wmask;
  logic [BITS-1:0] sram_rd;
  logic            busy;

  fakeram7_req_ctrl #(.BITS(BITS), .WORD_DEPTH(DEP), .ADDR_WIDTH(AW), .RSP_DEPTH(RSPD)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wd(sram_wd), .sram_wmask(sram_wmask), .sram_rd(sram_rd), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int rdy_mode = 0;        // 0: hold low, 1: hold high, 2: random
  int n_rd_fired = 0;
  int n_rsp = 0;
  logic [BITS-1:0] last_rsp = '0;

  logic [BITS-1:0] macro_mem [DEP];
  logic [BITS-1:0] ref_mem [DEP];
  logic [BITS-1:0] exp_q [$];
  int              fire_cyc_q [$];

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #2;
    rsp_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
  end

  // Behavioural macro: masked write commits at the edge, read data appears the following cycle.
  always @(posedge clk) begin
    if (sram_ce && sram_we)
      macro_mem[sram_addr] <= (macro_mem[sram_addr] & ~sram_wmask) | (sram_wd & sram_wmask);
    if (sram_ce && !sram_we) sram_rd <= macro_mem[sram_addr];
    else                     sram_rd <= {$urandom, $urandom};
  end

  // Reference: every accepted read owes one response, deliverable two cycles after its fire.
  always @(negedge clk) begin
    if (!rst) begin
      logic f;
      logic exp_vld;
      f = req_valid && req_ready;
      exp_vld = 1'b0;
      if (exp_q.size() != 0) exp_vld = (cyc >= fire_cyc_q[0] + 2);
      check_eq("req_ready", req_ready, exp_q.size() < RSPD);
      check_eq("busy", busy, exp_q.size() != 0);
      check_eq("rsp_valid", rsp_valid, exp_vld);
      check_eq("sram_ce", sram_ce, f);
      check_eq("sram_we", sram_we, f && req_we);
      check_eq("sram_addr", sram_addr, f ? req_addr : '0);
      check_eq("sram_wd", sram_wd, f ? req_wdata : '0);
      check_eq("sram_wmask", sram_wmask, f ? req_wmask : '0);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("rsp_unexpected", 1, 0);
        end else begin
          check_eq("rsp_rdata", rsp_rdata, exp_q[0]);
          void'(exp_q.pop_front());
          void'(fire_cyc_q.pop_front());
        end
        last_rsp = rsp_rdata;
        n_rsp++;
      end
      if (f) begin
        if (req_we) begin
          ref_mem[req_addr] = (ref_mem[req_addr] & ~req_wmask) | (req_wdata & req_wmask);
        end else begin
          exp_q.push_back(ref_mem[req_addr]);
          fire_cyc_q.push_back(cyc);
          n_rd_fired++;
        end
      end
    end
  end

  task automatic send(input logic we, input logic [AW-1:0] addr,
                      input logic [BITS-1:0] wd, input logic [BITS-1:0] wm);
    int t;
    t = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    req_wmask = wm;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      t++;
      if (t > 200) begin
        check_eq("send_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_wmask = '0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0) begin
      @(posedge clk);
      #1;
      t++;
      if (t > 500) begin
        check_eq("drain_timeout", exp_q.size(), 0);
        break;
      end
    end
  endtask

  initial begin
    int base_fired;
    int base_rsp;
    int t0;
    for (int i = 0; i < DEP; i++) begin
      macro_mem[i] = '0;
      ref_mem[i]   = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_rsp_valid", rsp_valid, 0);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_rsp_rdata", rsp_rdata, 0);
    check_eq("reset_req_ready", req_ready, 1);
    check_eq("reset_sram_ce", sram_ce, 0);
    rst = 1'b0;
    rdy_mode = 1;
    @(posedge clk);
    #1;

    send(1'b1, 9'h05, 64'hDEADBEEF_01234567, '1);
    send(1'b0, 9'h05, '0, '0);
    wait_drain();
    check_eq("t1_data", last_rsp, 64'hDEADBEEF_01234567);

    send(1'b1, 9'h05, '0, 64'h00000000_FFFFFFFF);
    send(1'b0, 9'h05, '0, '0);
    wait_drain();
    check_eq("t2_data", last_rsp, 64'hDEADBEEF_00000000);

    for (int i = 0; i < 16; i++)
      if (i != 5) send(1'b1, AW'(i), {32'hC0DE0000 | 32'(i), 32'(~i)}, '1);

    rdy_mode = 0;
    @(posedge clk);
    #1;
    base_fired = n_rd_fired;
    base_rsp   = n_rsp;
    fork
      begin
        for (int i = 1; i <= 5; i++) send(1'b0, AW'(i), '0, '0);
      end
      begin
        repeat (10) @(posedge clk);
        #1;
        check_eq("t3_accepted", n_rd_fired - base_fired, 3);
        check_eq("t3_req_ready", req_ready, 0);
        rdy_mode = 1;
      end
    join
    wait_drain();
    check_eq("t3_responses", n_rsp - base_rsp, 5);

    base_rsp = n_rsp;
    t0 = cyc;
    for (int i = 0; i < 16; i++) send(1'b0, AW'(i), '0, '0);
    check_eq("t4_no_stall", cyc - t0, 16);
    wait_drain();
    check_eq("t4_responses", n_rsp - base_rsp, 16);

    rdy_mode = 0;
    for (int i = 0; i < 3; i++) send(1'b0, AW'(i + 7), '0, '0);
    rst = 1'b1;
    #1;
    check_eq("t5_rsp_valid", rsp_valid, 0);
    check_eq("t5_busy", busy, 0);
    check_eq("t5_rsp_rdata", rsp_rdata, 0);
    check_eq("t5_req_ready", req_ready, 1);
    exp_q.delete();
    fire_cyc_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rdy_mode = 1;
    send(1'b0, 9'h05, '0, '0);
    wait_drain();
    check_eq("t5_post_reset_data", last_rsp, 64'hDEADBEEF_00000000);

    repeat (20) @(posedge clk);
    #1;
    check_eq("t6_sram_ce", sram_ce, 0);
    check_eq("t6_sram_we", sram_we, 0);
    check_eq("t6_busy", busy, 0);

    rdy_mode = 2;
    for (int n = 0; n < 300; n++) begin
      int gap;
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      send(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
           {$urandom, $urandom}, {$urandom, $urandom});
    end
    rdy_mode = 1;
    wait_drain();
    repeat (3) @(posedge clk);
    #1;
    check_eq("final_empty", exp_q.size(), 0);
    check_eq("final_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got cycle %0d, expected completion", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

endmodule
